exec_stage: RTL and testbench
=============================

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on posedge clock.
REQ-002 SHALL have port: reset_n  in  1  synchronous, active-low reset, sampled on posedge clock.
REQ-003 SHALL have ports: stall, bubble  in  1 each  E-register hold / inject-nop controls from the pipeline controller.
REQ-004 SHALL have ports: d_stat [0:2], d_icode [0:3], d_ifun [0:3], d_dstE [0:3], d_dstM [0:3]  in  decode-stage fields.
REQ-005 SHALL have ports: d_valA, d_valB, d_valC  in  [0:63]  operands from the register file read and fetch.
REQ-006 SHALL have ports: e_stat [0:2], e_icode [0:3], e_dstM [0:3], e_valA [0:63]  out  E-register pass-through to memory stage.
REQ-007 SHALL have ports: e_valE [0:63], e_dstE [0:3], e_cnd 1  out  ALU result, conditional destination, condition flag.
REQ-008 SHALL have port: cc  out  [0:2]  condition codes {ZF,SF,OF}.

Function
REQ-009 SHALL latch all d_* inputs into the E register on posedge clock when stall=0 and bubble=0.
REQ-010 SHALL hold the E register when stall=1; stall SHALL take priority over bubble.
REQ-011 SHALL load a nop on bubble=1, stall=0: icode=1, ifun=0, stat=1 (AOK), dstE=dstM=4'hF, operands 0.
REQ-012 SHALL compute e_valE, e_cnd, e_dstE combinationally from the E register and cc; latency one edge from d_* to e_valE.
REQ-013 SHALL select aluA: valA for icode 2,6; valC for 3,4,5; -8 for 8,A; +8 for 9,B; 0 otherwise.
REQ-014 SHALL select aluB: valB for icode 4,5,6,8,9,A,B; 0 otherwise.
REQ-015 SHALL use ifun as ALU function for icode 6 (0 add, 1 aluB-aluA, 2 and, 3 xor), add otherwise; 64-bit wrap-around, no carry out.
REQ-016 SHALL for icode 6 with ifun>3 drive e_valE=0 and leave cc unchanged.
REQ-017 SHALL update cc on posedge clock when E holds icode 6, ifun<=3, stat=AOK, stall=0: ZF=(result==0), SF=result[0], OF per signed two's-complement overflow of the selected add/sub; and/xor SHALL set OF=0.
REQ-018 SHALL evaluate e_cnd from the current (pre-update) cc by ifun: 0 always, 1 (SF^OF)|ZF, 2 SF^OF, 3 ZF, 4 ~ZF, 5 ~(SF^OF), 6 ~(SF^OF)&~ZF, 7-15 0.
REQ-019 SHALL drive e_cnd=0 for icodes other than 2 and 7.
REQ-020 SHALL drive e_dstE=4'hF when icode=2 and e_cnd=0, else the latched dstE.
REQ-021 SHALL not update cc while E holds a bubble or non-AOK stat.

Reset
REQ-022 SHALL on reset_n=0 at posedge clock load the E register with the bubble value of REQ-011, overriding stall and bubble.
REQ-023 SHALL on reset set cc=3'b100 (ZF=1, SF=0, OF=0); consequently e_valE=0, e_cnd=0, e_dstE=4'hF, e_stat=1 after reset.
REQ-024 SHALL give reset asserted mid-operation priority over any in-flight cc update on the same edge.

Configuration
REQ-025 SHALL, with EXEC_CC_BLOCK_EN defined, add input set_cc_block (1 bit); when 1, cc SHALL NOT update on that edge (exception pending downstream).
REQ-026 SHALL, without EXEC_CC_BLOCK_EN, omit set_cc_block and update cc solely per REQ-017.

Verification
REQ-027 SHALL cover: reset_n=0 one edge -> cc=100, e_icode=1, e_dstE=F, e_valE=0.
REQ-028 SHALL cover: OPq add, valA=7FFF_FFFF_FFFF_FFFF, valB=1 -> e_valE=8000_0000_0000_0000, next edge cc=011.
REQ-029 SHALL cover: OPq sub, valA=5, valB=5 -> e_valE=0, cc=100; following cmovne (ifun 4) dstE=3 -> e_cnd=0, e_dstE=F.
REQ-030 SHALL cover: call (icode 8), valB=0x100 -> e_valE=0xF8; ret (icode 9), valB=0xF8 -> e_valE=0x100; cc unchanged.
REQ-031 SHALL cover: stall=1 and bubble=1 on same edge with new d_* -> E register and outputs unchanged; next edge bubble=1 only -> nop.
REQ-032 SHALL cover (EXEC_CC_BLOCK_EN): OPq xor valA=valB=3 with set_cc_block=1 -> e_valE=0, cc keeps prior value.

Source files
------------

// File: rtl/exec_stage.sv
// exec_stage -- Y86-64 style execute stage: the E pipeline register, the ALU,
// the condition codes and the branch/cmov condition evaluation.
//
// Ports
//   clock, reset_n        single clock; synchronous active-low reset
//   stall, bubble         E-register hold / inject-nop (stall wins)
//   d_stat..d_valC        decode-stage fields latched into E
//   e_stat, e_icode,
//   e_dstM, e_valA        E-register pass-through to the memory stage
//   e_valE, e_dstE, e_cnd ALU result, conditional destination, condition flag
//   cc                    condition codes {ZF,SF,OF}
//
// Optional feature: define EXEC_CC_BLOCK_EN to add input set_cc_block, which
// suppresses the condition-code update on an edge (exception pending
// downstream). Without it, cc updates on every eligible OPq.
module exec_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        bubble,
`ifdef EXEC_CC_BLOCK_EN
  input  logic        set_cc_block,
`endif
  input  logic [2:0]  d_stat,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic [63:0] d_valA,
  input  logic [63:0] d_valB,
  input  logic [63:0] d_valC,
  output logic [2:0]  e_stat,
  output logic [3:0]  e_icode,
  output logic [3:0]  e_dstM,
  output logic [63:0] e_valA,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_cnd,
  output logic [2:0]  cc
);

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
  } ereg_t;

  localparam ereg_t NOP = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, dstE: 4'hF,
                            dstM: 4'hF, valA: 64'd0, valB: 64'd0, valC: 64'd0};
  localparam logic [3:0] I_CMOV = 4'h2, I_OPQ = 4'h6, I_JXX = 4'h7;
  localparam logic [2:0] S_AOK  = 3'd1;

  ereg_t       ereg_q, ereg_d;
  logic [2:0]  cc_q, cc_d;

  logic [63:0] alu_a, alu_b, alu_res, sum, diff;
  logic        alu_of, is_op, op_ok, cc_we, cc_block, zf, sf, of, cnd;

`ifdef EXEC_CC_BLOCK_EN
  assign cc_block = set_cc_block;
`else
  assign cc_block = 1'b0;
`endif

  // ---------------------------------------------------------------- E register
  always_comb begin
    ereg_d = ereg_q;
    if (!stall) begin
      if (bubble) ereg_d = NOP;
      else        ereg_d = '{stat: d_stat, icode: d_icode, ifun: d_ifun,
                             dstE: d_dstE, dstM: d_dstM, valA: d_valA,
                             valB: d_valB, valC: d_valC};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) ereg_q <= NOP;
    else          ereg_q <= ereg_d;
  end

  // ---------------------------------------------------------------- ALU
  always_comb begin
    alu_a = 64'd0;
    case (ereg_q.icode)
      4'h2, 4'h6:       alu_a = ereg_q.valA;
      4'h3, 4'h4, 4'h5: alu_a = ereg_q.valC;
      4'h8, 4'hA:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;  // push/call: -8
      4'h9, 4'hB:       alu_a = 64'd8;                    // pop/ret:   +8
      default:          alu_a = 64'd0;
    endcase
  end

  always_comb begin
    alu_b = 64'd0;
    case (ereg_q.icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = ereg_q.valB;
      default:                                  alu_b = 64'd0;
    endcase
  end

  assign is_op = (ereg_q.icode == I_OPQ);
  assign op_ok = is_op && (ereg_q.ifun <= 4'd3);
  assign sum   = alu_b + alu_a;
  assign diff  = alu_b - alu_a;

  // Non-OPq instructions always add; an OPq with an undefined ifun yields 0.
  always_comb begin
    alu_res = sum;
    alu_of  = (alu_a[63] == alu_b[63]) && (sum[63] != alu_a[63]);
    if (is_op) begin
      case (ereg_q.ifun)
        4'd0: ; // add, defaults above
        4'd1: begin
          alu_res = diff;
          alu_of  = (alu_a[63] != alu_b[63]) && (diff[63] != alu_b[63]);
        end
        4'd2: begin alu_res = alu_b & alu_a; alu_of = 1'b0; end
        4'd3: begin alu_res = alu_b ^ alu_a; alu_of = 1'b0; end
        default: begin alu_res = 64'd0; alu_of = 1'b0; end
      endcase
    end
  end

  // ---------------------------------------------------------------- cc
  // Bubbles (icode 1) and non-AOK instructions never qualify; a stalled E
  // would otherwise re-apply the same update on every held edge.
  assign cc_we = op_ok && (ereg_q.stat == S_AOK) && !stall && !cc_block;
  assign cc_d  = cc_we ? {alu_res == 64'd0, alu_res[63], alu_of} : cc_q;

  always_ff @(posedge clock) begin
    if (!reset_n) cc_q <= 3'b100;
    else          cc_q <= cc_d;
  end

  // ---------------------------------------------------------------- condition
  assign zf = cc_q[2];
  assign sf = cc_q[1];
  assign of = cc_q[0];

  always_comb begin
    cnd = 1'b0;
    case (ereg_q.ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (sf ^ of) | zf;
      4'd2:    cnd = sf ^ of;
      4'd3:    cnd = zf;
      4'd4:    cnd = ~zf;
      4'd5:    cnd = ~(sf ^ of);
      4'd6:    cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

  assign e_cnd   = ((ereg_q.icode == I_CMOV) || (ereg_q.icode == I_JXX)) ? cnd : 1'b0;
  assign e_dstE  = ((ereg_q.icode == I_CMOV) && !e_cnd) ? 4'hF : ereg_q.dstE;
  assign e_valE  = alu_res;
  assign e_stat  = ereg_q.stat;
  assign e_icode = ereg_q.icode;
  assign e_dstM  = ereg_q.dstM;
  assign e_valA  = ereg_q.valA;
  assign cc      = cc_q;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: a driver applies stimulus on the falling
// edge and pushes the model's post-edge expectation; a monitor pops and
// compares one entry after every rising edge.
module tb_exec_stage;

  logic        clock = 1'b0;
  logic        reset_n, stall, bubble, blk;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB, d_valC;
  logic [2:0]  e_stat, cc;
  logic [3:0]  e_icode, e_dstM, e_dstE;
  logic [63:0] e_valA, e_valE;
  logic        e_cnd;

  always #5 clock = ~clock;

  exec_stage dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .bubble(bubble),
`ifdef EXEC_CC_BLOCK_EN
    .set_cc_block(blk),
`endif
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_dstE(d_dstE),
    .d_dstM(d_dstM), .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
    .e_stat(e_stat), .e_icode(e_icode), .e_dstM(e_dstM), .e_valA(e_valA),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .cc(cc)
  );

  typedef struct {
    logic [2:0] stat; logic [3:0] icode, ifun, dstE, dstM;
    logic [63:0] valA, valB, valC;
  } ins_t;

  typedef struct {
    logic [2:0] stat, cc; logic [3:0] icode, dstM, dstE;
    logic [63:0] valA, valE; logic cnd;
  } exp_t;

  exp_t sb[$];
  ins_t m_e;
  logic [2:0] m_cc;
  int   n_pass = 0, n_total = 0;

  function automatic ins_t nop_ins();
    ins_t n;
    n.stat = 3'd1; n.icode = 4'h1; n.ifun = 4'h0; n.dstE = 4'hF; n.dstM = 4'hF;
    n.valA = 64'd0; n.valB = 64'd0; n.valC = 64'd0;
    return n;
  endfunction

  // Reference ALU: overflow from exact 65-bit signed arithmetic.
  function automatic void model_alu(input ins_t e, output logic [63:0] v,
                                    output logic [2:0] fl);
    logic [63:0] a, b;
    logic signed [64:0] wide;
    logic o;
    a = 64'd0; b = 64'd0; o = 1'b0;
    if (e.icode inside {4'h2, 4'h6})             a = e.valA;
    else if (e.icode inside {4'h3, 4'h4, 4'h5})  a = e.valC;
    else if (e.icode inside {4'h8, 4'hA})        a = -64'sd8;
    else if (e.icode inside {4'h9, 4'hB})        a = 64'd8;
    if (e.icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) b = e.valB;
    if (e.icode == 4'h6 && e.ifun == 4'd1) begin
      wide = $signed({b[63], b}) - $signed({a[63], a});
      v = wide[63:0]; o = (wide != $signed({v[63], v}));
    end else if (e.icode == 4'h6 && e.ifun == 4'd2) v = a & b;
    else if (e.icode == 4'h6 && e.ifun == 4'd3)     v = a ^ b;
    else if (e.icode == 4'h6 && e.ifun > 4'd3)      v = 64'd0;
    else begin
      wide = $signed({b[63], b}) + $signed({a[63], a});
      v = wide[63:0]; o = (wide != $signed({v[63], v}));
    end
    fl = {v == 64'd0, v[63], o};
  endfunction

  function automatic exp_t model_out(input ins_t e, input logic [2:0] c);
    exp_t x;
    logic [2:0] fl;
    logic z, s, o, less;
    z = c[2]; s = c[1]; o = c[0]; less = s ^ o;
    model_alu(e, x.valE, fl);
    x.stat = e.stat; x.icode = e.icode; x.dstM = e.dstM; x.valA = e.valA; x.cc = c;
    x.cnd = 1'b0;
    if (e.icode == 4'h2 || e.icode == 4'h7)
      case (e.ifun)
        4'd0: x.cnd = 1'b1;
        4'd1: x.cnd = less || z;
        4'd2: x.cnd = less;
        4'd3: x.cnd = z;
        4'd4: x.cnd = !z;
        4'd5: x.cnd = !less;
        4'd6: x.cnd = !less && !z;
        default: x.cnd = 1'b0;
      endcase
    x.dstE = (e.icode == 4'h2 && !x.cnd) ? 4'hF : e.dstE;
    return x;
  endfunction

  // One clock of stimulus: drive on the falling edge, advance the model over
  // the coming rising edge, and queue what the DUT must show afterwards.
  task automatic drive(input logic rst_n, input logic st, input logic bb,
                       input logic cblk, input ins_t d);
    logic [63:0] v;
    logic [2:0]  fl;
    logic        blk_eff;
    @(negedge clock);
    reset_n = rst_n; stall = st; bubble = bb;
`ifdef EXEC_CC_BLOCK_EN
    blk = cblk;
`else
    blk = 1'b0;
`endif
    blk_eff = blk;
    d_stat = d.stat; d_icode = d.icode; d_ifun = d.ifun; d_dstE = d.dstE;
    d_dstM = d.dstM; d_valA = d.valA; d_valB = d.valB; d_valC = d.valC;
    model_alu(m_e, v, fl);
    if (!rst_n) m_cc = 3'b100;
    else if (!st && m_e.icode == 4'h6 && m_e.ifun <= 4'd3 && m_e.stat == 3'd1
             && !blk_eff) m_cc = fl;
    if (!rst_n)   m_e = nop_ins();
    else if (!st) m_e = bb ? nop_ins() : d;
    sb.push_back(model_out(m_e, m_cc));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("e_stat",  64'(e_stat),  64'(x.stat));
        check("e_icode", 64'(e_icode), 64'(x.icode));
        check("e_dstM",  64'(e_dstM),  64'(x.dstM));
        check("e_valA",  e_valA,       x.valA);
        check("e_valE",  e_valE,       x.valE);
        check("e_dstE",  64'(e_dstE),  64'(x.dstE));
        check("e_cnd",   64'(e_cnd),   64'(x.cnd));
        check("cc",      64'(cc),      64'(x.cc));
      end
    end
  end

  function automatic ins_t mk(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic [3:0] de);
    ins_t n;
    n.stat = 3'd1; n.icode = ic; n.ifun = fn; n.dstE = de; n.dstM = 4'h5;
    n.valA = a; n.valB = b; n.valC = c;
    return n;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    case ($urandom_range(0, 5))
      0: r = 64'd0;
      1: r = 64'h7FFF_FFFF_FFFF_FFFF;
      2: r = 64'h8000_0000_0000_0000;
      3: r = 64'(int'($urandom_range(0, 20)) - 10);
      default: r = {$urandom(), $urandom()};
    endcase
    return r;
  endfunction

  initial begin : driver
    ins_t r, nop;
    nop = nop_ins();
    reset_n = 1'b0; stall = 1'b0; bubble = 1'b0; blk = 1'b0;
    m_e = nop; m_cc = 3'b100;
    // Reset overrides stall and bubble.
    drive(1'b0, 1'b1, 1'b1, 1'b0, mk(4'h6, 4'h0, 64'd9, 64'd9, 64'd9, 4'h2));
    // add overflow: 7FFF.. + 1 -> 8000.., cc=011 next edge
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2));
    drive(1'b1, 1'b0, 1'b1, 1'b0, nop);
    // sub 5-5 -> 0, cc=100; cmovne then not taken -> dstE=F
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2));
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(4'h2, 4'h4, 64'h1234, 64'd0, 64'd0, 4'h3));
    drive(1'b1, 1'b0, 1'b1, 1'b0, nop);
    // call / ret stack arithmetic, cc untouched
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(4'h8, 4'h0, 64'd0, 64'h100, 64'h40, 4'h4));
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(4'h9, 4'h0, 64'd0, 64'hF8, 64'd0, 4'h4));
    drive(1'b1, 1'b0, 1'b1, 1'b0, nop);
    // stall+bubble holds E (and blocks the cc update); bubble alone -> nop
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(4'h6, 4'h1, 64'd3, 64'd1, 64'd0, 4'h6));
    drive(1'b1, 1'b1, 1'b1, 1'b0, mk(4'h3, 4'h0, 64'd7, 64'd7, 64'd77, 4'h1));
    drive(1'b1, 1'b0, 1'b1, 1'b0, nop);
    // xor 3^3 with cc update blocked on the following edge
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(4'h6, 4'h3, 64'd3, 64'd3, 64'd0, 4'h7));
    drive(1'b1, 1'b0, 1'b1, 1'b1, nop);
    drive(1'b1, 1'b0, 1'b1, 1'b0, nop);
    // reset on the edge where an OPq would update cc
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(4'h6, 4'h1, 64'd3, 64'd5, 64'd0, 4'h2));
    drive(1'b0, 1'b0, 1'b0, 1'b0, nop);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1: r.icode = 4'h6;
        2:    r.icode = 4'h2;
        3:    r.icode = 4'h7;
        default: r.icode = 4'($urandom_range(0, 15));
      endcase
      r.ifun  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
      r.stat  = ($urandom_range(0, 7) != 0) ? 3'd1 : 3'($urandom_range(2, 4));
      r.dstE  = 4'($urandom_range(0, 15));
      r.dstM  = 4'($urandom_range(0, 15));
      r.valA  = rnd64(); r.valB = rnd64(); r.valC = rnd64();
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, r);
    end
    repeat (3) @(negedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
